rf_alu_arbiter: RTL and testbench

//  Shares the Register_file and ALU_16B between two command requesters (req 0 = SYS_CTRL, req 1 = secondary host).

---
 rtl/rf_alu_arbiter_pkg.sv | 22 ++
 rtl/rf_alu_arbiter_rr_arb2.sv | 22 ++
 rtl/rf_alu_arbiter.sv | 174 +++++++++++++++++
 tb/tb_rf_alu_arbiter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_alu_arbiter_pkg.sv
// Shared opcode and state encodings for the RF/ALU arbiter.
// Requester commands and FSM states are both 2-bit binary codes.
package rf_alu_arbiter_pkg;

    localparam int NUM_REQ = 2;

    localparam logic [1:0] OP_WR  = 2'b00;
    localparam logic [1:0] OP_RD  = 2'b01;
    localparam logic [1:0] OP_ALU = 2'b10;
    localparam logic [1:0] OP_ILL = 2'b11;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_ISSUE = 2'b01;
    localparam logic [1:0] ST_WAIT  = 2'b10;
    localparam logic [1:0] ST_RESP  = 2'b11;

    // Reads and ALU ops must wait for a valid strobe from the shared resource.
    function automatic logic op_needs_wait(input logic [1:0] op);
        return (op == OP_RD) || (op == OP_ALU);
    endfunction

endpackage

// File: rtl/rf_alu_arbiter_rr_arb2.sv
// Two-way round-robin pick: the pointed-to side wins when it requests,
// otherwise the other side. Purely combinational, one-hot result.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] win
);

    logic alt;

    assign alt = ~ptr;

    always_comb begin
        win = '0;
        if (req[ptr]) begin
            win[ptr] = 1'b1;
        end else if (req[alt]) begin
            win[alt] = 1'b1;
        end
    end

endmodule

// File: rtl/rf_alu_arbiter.sv
// Arbitrates the register file and ALU between two command requesters,
// running one transaction at a time and returning data or an error.
module rf_alu_arbiter
    import rf_alu_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int RF_ADDR    = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [1:0]                REQ,
    input  logic [3:0]                OP,
    input  logic [2*RF_ADDR-1:0]      ADDR,
    input  logic [2*DATA_WIDTH-1:0]   WDATA,
    input  logic [7:0]                FUN,
    output logic [1:0]                GNT,
    output logic [1:0]                RSP_VLD,
    output logic [2*DATA_WIDTH-1:0]   RSP_DATA,
    output logic                      RSP_ERR,
    output logic                      RF_WrEn,
    output logic                      RF_RdEn,
    output logic [RF_ADDR-1:0]        RF_Address,
    output logic [DATA_WIDTH-1:0]     RF_WrData,
    input  logic [DATA_WIDTH-1:0]     RF_RdData,
    input  logic                      RF_RdData_VLD,
    output logic                      ALU_EN,
    output logic [3:0]                ALU_FUN,
    input  logic [2*DATA_WIDTH-1:0]   ALU_OUT,
    input  logic                      ALU_OUT_VLD,
    output logic                      CLKG_EN
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam int RSP_W = 2 * DATA_WIDTH;

    logic [1:0]            state_reg, state_next;
    logic                  ptr_reg, ptr_next;
    logic                  owner_reg, owner_next;
    logic [1:0]            op_reg, op_next;
    logic [RF_ADDR-1:0]    addr_reg, addr_next;
    logic [DATA_WIDTH-1:0] wdata_reg, wdata_next;
    logic [3:0]            fun_reg, fun_next;
    logic [RSP_W-1:0]      data_reg, data_next;
    logic                  err_reg, err_next;
    logic [CNT_W-1:0]      cnt_reg, cnt_next;

    logic [1:0]            op_arr    [NUM_REQ];
    logic [RF_ADDR-1:0]    addr_arr  [NUM_REQ];
    logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];
    logic [3:0]            fun_arr   [NUM_REQ];

    logic [1:0] win;
    logic       win_idx;
    logic       busy;
    logic       is_alu;

    rr_arb2 u_rr_arb2 (
        .req (REQ),
        .ptr (ptr_reg),
        .win (win)
    );

    assign win_idx = win[1];
    assign busy    = (state_reg != ST_IDLE);
    assign is_alu  = (op_reg == OP_ALU);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign op_arr[gi]    = OP[2*gi +: 2];
            assign addr_arr[gi]  = ADDR[RF_ADDR*gi +: RF_ADDR];
            assign wdata_arr[gi] = WDATA[DATA_WIDTH*gi +: DATA_WIDTH];
            assign fun_arr[gi]   = FUN[4*gi +: 4];
            assign GNT[gi]       = (state_reg == ST_ISSUE) && (owner_reg == 1'(gi));
            assign RSP_VLD[gi]   = (state_reg == ST_RESP) && (owner_reg == 1'(gi));
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        owner_next = owner_reg;
        op_next    = op_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        fun_next   = fun_reg;
        data_next  = data_reg;
        err_next   = err_reg;
        cnt_next   = cnt_reg;

        case (state_reg)
            ST_IDLE: begin
                if (win != 2'b00) begin
                    owner_next = win_idx;
                    ptr_next   = ~win_idx;
                    op_next    = op_arr[win_idx];
                    addr_next  = addr_arr[win_idx];
                    wdata_next = wdata_arr[win_idx];
                    fun_next   = fun_arr[win_idx];
                    data_next  = '0;
                    err_next   = 1'b0;
                    cnt_next   = '0;
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (op_needs_wait(op_reg)) begin
                    state_next = ST_WAIT;
                end else begin
                    err_next   = (op_reg != OP_WR);
                    state_next = ST_RESP;
                end
            end
            ST_WAIT: begin
                // Only the valid belonging to the resource in use is honoured.
                if ((op_reg == OP_RD) && RF_RdData_VLD) begin
                    data_next  = RSP_W'(RF_RdData);
                    state_next = ST_RESP;
                end else if (is_alu && ALU_OUT_VLD) begin
                    data_next  = ALU_OUT;
                    state_next = ST_RESP;
                end else if (cnt_reg == CNT_W'(TIMEOUT)) begin
                    data_next  = '0;
                    err_next   = 1'b1;
                    state_next = ST_RESP;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_reg <= ST_IDLE;
            ptr_reg   <= 1'b0;
            owner_reg <= 1'b0;
            op_reg    <= '0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            fun_reg   <= '0;
            data_reg  <= '0;
            err_reg   <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            owner_reg <= owner_next;
            op_reg    <= op_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
            fun_reg   <= fun_next;
            data_reg  <= data_next;
            err_reg   <= err_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Outputs decode from state so an async reset clears them at once.
    assign RF_WrEn    = (state_reg == ST_ISSUE) && (op_reg == OP_WR);
    assign RF_RdEn    = (state_reg == ST_ISSUE) && (op_reg == OP_RD);
    assign ALU_EN     = (state_reg == ST_ISSUE) && is_alu;
    assign CLKG_EN    = ((state_reg == ST_ISSUE) || (state_reg == ST_WAIT)) && is_alu;
    assign RF_Address = busy ? addr_reg  : '0;
    assign RF_WrData  = busy ? wdata_reg : '0;
    assign ALU_FUN    = busy ? fun_reg   : '0;
    assign RSP_DATA   = (state_reg == ST_RESP) ? data_reg : '0;
    assign RSP_ERR    = (state_reg == ST_RESP) && err_reg;

endmodule

// File: tb/tb_rf_alu_arbiter.sv
// Self-checking bench: vector table plus hand sequences, a scoreboard queue
// of expected grants/responses, and behavioural RF and ALU responders.
module tb_rf_alu_arbiter;

    localparam int TO = 15;

    logic        CLK;
    logic        RST;
    logic [1:0]  REQ;
    logic [3:0]  OP;
    logic [7:0]  ADDR;
    logic [15:0] WDATA;
    logic [7:0]  FUN;
    logic [1:0]  GNT;
    logic [1:0]  RSP_VLD;
    logic [15:0] RSP_DATA;
    logic        RSP_ERR;
    logic        RF_WrEn;
    logic        RF_RdEn;
    logic [3:0]  RF_Address;
    logic [7:0]  RF_WrData;
    logic [7:0]  RF_RdData;
    logic        RF_RdData_VLD;
    logic        ALU_EN;
    logic [3:0]  ALU_FUN;
    logic [15:0] ALU_OUT;
    logic        ALU_OUT_VLD;
    logic        CLKG_EN;

    rf_alu_arbiter #(.DATA_WIDTH(8), .RF_ADDR(4), .TIMEOUT(TO)) dut (
        .CLK(CLK), .RST(RST), .REQ(REQ), .OP(OP), .ADDR(ADDR), .WDATA(WDATA), .FUN(FUN),
        .GNT(GNT), .RSP_VLD(RSP_VLD), .RSP_DATA(RSP_DATA), .RSP_ERR(RSP_ERR),
        .RF_WrEn(RF_WrEn), .RF_RdEn(RF_RdEn), .RF_Address(RF_Address), .RF_WrData(RF_WrData),
        .RF_RdData(RF_RdData), .RF_RdData_VLD(RF_RdData_VLD),
        .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN), .ALU_OUT(ALU_OUT), .ALU_OUT_VLD(ALU_OUT_VLD),
        .CLKG_EN(CLKG_EN)
    );

    typedef struct {
        int         id;
        logic [1:0] op;
        logic [3:0] addr;
        logic [7:0] wdata;
        logic [3:0] fun;
        bit         alu_ok;
        logic [15:0] exp_data;
        bit         exp_err;
        int         exp_lat;
    } vec_t;

    typedef struct {
        logic [1:0]  gnt;
        logic [15:0] data;
        bit          err;
        int          lat;
    } exp_t;

    exp_t       sb[$];
    vec_t       vecs[10];
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         gnt_cyc = 0;
    bit         alu_ok = 1'b1;
    logic [7:0] mem[16];

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] all_out();
        return {23'd0, GNT, RSP_VLD, RSP_DATA, RSP_ERR, RF_WrEn, RF_RdEn, RF_Address,
                RF_WrData, ALU_EN, ALU_FUN, CLKG_EN};
    endfunction

    // RF and ALU stand-ins: answer one cycle after the strobe.
    initial begin
        logic       rd_hit, alu_hit;
        logic [7:0] rd_val;
        logic [15:0] alu_val;
        RF_RdData_VLD = 1'b0;
        RF_RdData     = '0;
        ALU_OUT_VLD   = 1'b0;
        ALU_OUT       = '0;
        for (int j = 0; j < 16; j++) mem[j] = 8'h10 + 8'(j);
        forever begin
            @(negedge CLK);
            rd_hit  = RF_RdEn;
            alu_hit = ALU_EN && alu_ok;
            rd_val  = mem[RF_Address];
            alu_val = 16'hBE00 | {12'h000, ALU_FUN};
            if (RF_WrEn) mem[RF_Address] = RF_WrData;
            @(posedge CLK);
            #1;
            RF_RdData_VLD = rd_hit;
            RF_RdData     = rd_hit ? rd_val : 8'h00;
            ALU_OUT_VLD   = alu_hit;
            ALU_OUT       = alu_hit ? alu_val : 16'h0000;
        end
    end

    // Scoreboard monitor: grant owner and response contents/latency.
    always @(negedge CLK) begin
        exp_t e;
        if (GNT != 2'b00) begin
            if (sb.size() == 0) check("gnt_unexpected", 64'(GNT), 64'd0);
            else                check("gnt_owner", 64'(GNT), 64'(sb[0].gnt));
            gnt_cyc = cyc;
        end
        if (RSP_VLD != 2'b00) begin
            if (sb.size() == 0) begin
                check("rsp_unexpected", 64'(RSP_VLD), 64'd0);
            end else begin
                e = sb.pop_front();
                $display("rsp vld=%b data=%h err=%b lat=%0d", RSP_VLD, RSP_DATA, RSP_ERR, cyc - gnt_cyc);
                check("rsp_vld", 64'(RSP_VLD), 64'(e.gnt));
                check("rsp_data", 64'(RSP_DATA), 64'(e.data));
                check("rsp_err", 64'(RSP_ERR), 64'(e.err));
                check("rsp_lat", 64'(cyc - gnt_cyc), 64'(e.lat));
            end
        end
    end

    task automatic wait_gnt(input int id, output bit ok);
        int n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!GNT[id] && n < 20);
        ok = GNT[id];
        check("gnt_seen", 64'(ok), 64'd1);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(negedge CLK);
            n++;
        end
        check("rsp_seen", 64'(sb.size()), 64'd0);
        sb.delete();
    endtask

    task automatic run_vec(input vec_t v);
        bit ok;
        sb.push_back('{2'(1 << v.id), v.exp_data, v.exp_err, v.exp_lat});
        alu_ok = v.alu_ok;
        OP[2*v.id +: 2]    = v.op;
        ADDR[4*v.id +: 4]  = v.addr;
        WDATA[8*v.id +: 8] = v.wdata;
        FUN[4*v.id +: 4]   = v.fun;
        REQ[v.id]          = 1'b1;
        wait_gnt(v.id, ok);
        if (ok) begin
            check("issue_strobes", 64'({RF_WrEn, RF_RdEn, ALU_EN, CLKG_EN}),
                  64'({v.op == 2'b00, v.op == 2'b01, v.op == 2'b10, v.op == 2'b10}));
            check("issue_addr", 64'(RF_Address), 64'(v.addr));
            check("issue_fun", 64'(ALU_FUN), 64'(v.fun));
        end
        REQ[v.id] = 1'b0;
        wait_drain();
        @(negedge CLK);
        check("idle_addr", 64'(RF_Address), 64'd0);
    endtask

    initial begin
        bit ok;
        int g, n, clkg;

        vecs[0] = '{0, 2'b00, 4'd2, 8'hA5, 4'd0, 1'b1, 16'h0000, 1'b0, 1};
        vecs[1] = '{1, 2'b01, 4'd2, 8'h00, 4'd0, 1'b1, 16'h00A5, 1'b0, 2};
        vecs[2] = '{1, 2'b00, 4'd7, 8'h3C, 4'd0, 1'b1, 16'h0000, 1'b0, 1};
        vecs[3] = '{0, 2'b01, 4'd7, 8'h00, 4'd0, 1'b1, 16'h003C, 1'b0, 2};
        vecs[4] = '{0, 2'b10, 4'd0, 8'h00, 4'd3, 1'b1, 16'hBE03, 1'b0, 2};
        vecs[5] = '{1, 2'b10, 4'd1, 8'h00, 4'd9, 1'b1, 16'hBE09, 1'b0, 2};
        vecs[6] = '{0, 2'b11, 4'd4, 8'hFF, 4'd0, 1'b1, 16'h0000, 1'b1, 1};
        vecs[7] = '{1, 2'b01, 4'd5, 8'h00, 4'd0, 1'b1, 16'h0015, 1'b0, 2};
        vecs[8] = '{1, 2'b11, 4'd6, 8'h77, 4'd2, 1'b1, 16'h0000, 1'b1, 1};
        vecs[9] = '{0, 2'b01, 4'd4, 8'h00, 4'd0, 1'b1, 16'h0014, 1'b0, 2};

        RST = 1'b0; REQ = '0; OP = '0; ADDR = '0; WDATA = '0; FUN = '0;
        repeat (3) @(negedge CLK);
        check("reset_outputs", all_out(), 64'd0);
        RST = 1'b1;
        @(negedge CLK);

        for (int i = 0; i < 10; i++) begin
            $display("vector %0d: req=%0d op=%b addr=%0d", i, vecs[i].id, vecs[i].op, vecs[i].addr);
            run_vec(vecs[i]);
        end

        // ALU never answers: timeout error, clock gate held through ISSUE and WAIT.
        // Requester 1 raises and withdraws REQ while busy, which must not be granted.
        $display("alu timeout sequence");
        alu_ok = 1'b0;
        sb.push_back('{2'b01, 16'h0000, 1'b1, TO + 2});
        OP[1:0] = 2'b10; FUN[3:0] = 4'd0; ADDR[3:0] = 4'd3; OP[3:2] = 2'b00;
        REQ[0] = 1'b1;
        wait_gnt(0, ok);
        REQ[0] = 1'b0;
        clkg = 0; n = 0;
        while (sb.size() != 0 && n < 60) begin
            if (CLKG_EN) clkg++;
            if (n == 3) REQ[1] = 1'b1;
            if (n == 6) REQ[1] = 1'b0;
            @(negedge CLK);
            n++;
        end
        check("clkg_cycles", 64'(clkg), 64'(TO + 2));
        wait_drain();
        repeat (3) @(negedge CLK);
        check("withdrawn_idle", 64'(GNT), 64'd0);

        // Async reset in WAIT aborts the transaction with no response.
        $display("async reset sequence");
        sb.push_back('{2'b01, 16'h0000, 1'b1, TO + 2});
        OP[1:0] = 2'b10; FUN[3:0] = 4'd5;
        REQ[0] = 1'b1;
        wait_gnt(0, ok);
        REQ[0] = 1'b0;
        repeat (3) @(negedge CLK);
        check("pre_reset_clkg", 64'(CLKG_EN), 64'd1);
        #2 RST = 1'b0;
        #1 check("async_reset_outputs", all_out(), 64'd0);
        sb.delete();
        repeat (2) @(negedge CLK);
        check("held_reset_outputs", all_out(), 64'd0);
        RST = 1'b1;
        alu_ok = 1'b1;
        @(negedge CLK);
        run_vec('{1, 2'b00, 4'd8, 8'h5A, 4'd0, 1'b1, 16'h0000, 1'b0, 1});

        // Both requesters held: grants alternate starting from requester 0.
        $display("round-robin sequence");
        sb.push_back('{2'b01, 16'h0000, 1'b0, 1});
        sb.push_back('{2'b10, 16'h0000, 1'b0, 1});
        sb.push_back('{2'b01, 16'h0000, 1'b0, 1});
        sb.push_back('{2'b10, 16'h0000, 1'b0, 1});
        OP = 4'b0000; ADDR = {4'd10, 4'd9}; WDATA = {8'h22, 8'h11};
        REQ = 2'b11;
        g = 0; n = 0;
        while (g < 4 && n < 60) begin
            @(negedge CLK);
            n++;
            if (GNT != 2'b00) begin
                g++;
                if (g == 4) REQ = 2'b00;
            end
        end
        REQ = 2'b00;
        check("rr_grant_count", 64'(g), 64'd4);
        wait_drain();
        run_vec('{0, 2'b01, 4'd9, 8'h00, 4'd0, 1'b1, 16'h0011, 1'b0, 2});
        run_vec('{1, 2'b01, 4'd10, 8'h00, 4'd0, 1'b1, 16'h0022, 1'b0, 2});
        run_vec('{0, 2'b01, 4'd8, 8'h00, 4'd0, 1'b1, 16'h005A, 1'b0, 2});

        repeat (2) @(negedge CLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
